// File: rtl/vec_mult_pkg.sv
// Shared types and default sizing for the vector MAC sequencer.
package vec_mult_pkg;

    localparam int VEC_LEN_DEF  = 64;
    localparam int PIPE_LAT_DEF = 2;
    localparam int IDX_W_DEF    = $clog2(VEC_LEN_DEF);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/vec_mult_seq_ctrl_valid_delay_line.sv
// DEPTH-stage shift register carrying {valid, last} from operand read to
// accumulator input. Flush empties every stage in one cycle.
module valid_delay_line
    import vec_mult_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_flush,
    input  logic i_vld,
    input  logic i_last,
    output logic o_vld,
    output logic o_last,
    output logic o_empty
);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_last;
    logic             w_ahead;

    // Shift one stage per cycle; reset and flush clear the whole line.
    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            r_vld  <= '0;
            r_last <= '0;
        end else begin
            r_vld[0]  <= i_vld;
            r_last[0] <= i_vld & i_last;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_last[i] <= r_last[i-1];
            end
        end
    end

    // Valid bits that will still be in the line after this edge: the input
    // plus every stage except the output one.
    always_comb begin
        w_ahead = i_vld;
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_ahead = w_ahead | r_vld[i];
        end
    end

    // o_empty looks one edge ahead so the consumer can leave drain exactly
    // as the final element leaves the line.
    assign o_empty = ~w_ahead;
    assign o_vld   = r_vld[DEPTH-1];
    assign o_last  = r_last[DEPTH-1];

endmodule

// File: rtl/vec_mult_seq_ctrl.sv
// Dot-product sequencer: clears the accumulator, walks the operand index,
// issues pipeline-aligned MAC enables and hands the result to the consumer.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for start handshake
// ST_CLEAR  | one-cycle accumulator clear, index reset
// ST_RUN    | issuing operand reads, one per non-stalled cycle
// ST_DRAIN  | waiting for the multiplier pipeline to empty
// ST_RESULT | result valid, waiting for consumer handshake
module vec_mult_seq_ctrl
    import vec_mult_pkg::*;
#(
    parameter int VEC_LEN  = VEC_LEN_DEF,
    parameter int IDX_W    = $clog2(VEC_LEN),
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             abort,
    input  logic             stall,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    output logic             acc_clr,
    output logic             mac_en,
    output logic             mac_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(VEC_LEN - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_index;
    logic             r_acc_clr;
    logic             r_res_valid;
    logic             r_busy;

    logic             w_rd_en;
    logic             w_is_last;
    logic             w_line_empty;

    assign w_rd_en   = (r_state == ST_RUN) & ~stall;
    assign w_is_last = (r_index == LP_LAST_IDX);

    // Control FSM with registered status outputs; abort acts like a soft reset.
    always_ff @(posedge clk) begin
        if (!rstn || abort) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_acc_clr   <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_state   <= ST_CLEAR;
                        r_index   <= '0;
                        r_acc_clr <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_state   <= ST_RUN;
                    r_index   <= '0;
                    r_acc_clr <= 1'b0;
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (w_is_last) begin
                            r_index <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_line_empty) begin
                        r_state     <= ST_RESULT;
                        r_res_valid <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_index     <= '0;
                    r_acc_clr   <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Read strobe and its last-element tag ride the delay line to the accumulator.
    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (abort),
        .i_vld   (w_rd_en),
        .i_last  (w_is_last),
        .o_vld   (mac_en),
        .o_last  (mac_last),
        .o_empty (w_line_empty)
    );

    assign start_ready = (r_state == ST_IDLE) & ~abort;
    assign rd_en       = w_rd_en;
    assign rd_addr     = r_index;
    assign acc_clr     = r_acc_clr;
    assign res_valid   = r_res_valid;
    assign busy        = r_busy;

endmodule

// File: tb/tb_vec_mult_seq_ctrl.sv
// Directed bench for the dot-product sequencer.
module tb_vec_mult_seq_ctrl;

    localparam int VL = 64;
    localparam int PL = 2;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_valid;
    logic          start_ready;
    logic          abort;
    logic          stall;
    logic          rd_en;
    logic [IW-1:0] rd_addr;
    logic          acc_clr;
    logic          mac_en;
    logic          mac_last;
    logic          res_valid;
    logic          res_ready;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;

    vec_mult_seq_ctrl #(
        .VEC_LEN  (VL),
        .IDX_W    (IW),
        .PIPE_LAT (PL)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .abort       (abort),
        .stall       (stall),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .acc_clr     (acc_clr),
        .mac_en      (mac_en),
        .mac_last    (mac_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read strobe for cycle c of a run started at cycle 0.
    function automatic logic rd_exp(input int c, input int s_lo, input int s_hi, input int ns);
        return (c >= 2) && (c <= VL + 1 + ns) && !((c >= s_lo) && (c <= s_hi));
    endfunction

    // One full vector: optional stall window [s_lo,s_hi], result held for 'hold' cycles.
    task automatic run_vec(input string name, input int s_lo, input int s_hi, input int hold);
        int   ns;
        int   t_rv;
        int   n_mac;
        int   e_addr;
        logic e_rd;
        ns    = (s_hi >= s_lo) ? (s_hi - s_lo + 1) : 0;
        t_rv  = VL + 2 + PL + ns;
        n_mac = 0;
        for (int c = 0; c <= t_rv + hold + 1; c++) begin
            start_valid = (c == 0) || ((c >= t_rv) && (c < t_rv + hold));
            stall       = (c >= s_lo) && (c <= s_hi);
            res_ready   = (c >= t_rv + hold);
            @(negedge clk);
            e_rd = rd_exp(c, s_lo, s_hi, ns);
            chk({name, ":start_ready"}, 32'(start_ready), 32'((c == 0) || (c == t_rv + hold + 1)));
            chk({name, ":acc_clr"}, 32'(acc_clr), 32'(c == 1));
            chk({name, ":busy"}, 32'(busy), 32'((c >= 1) && (c <= t_rv + hold)));
            chk({name, ":rd_en"}, 32'(rd_en), 32'(e_rd));
            if (e_rd || stall) begin
                if (stall)          e_addr = s_lo - 2;
                else if (c > s_hi)  e_addr = c - 2 - ns;
                else                e_addr = c - 2;
                chk({name, ":rd_addr"}, 32'(rd_addr), 32'(e_addr));
            end
            chk({name, ":mac_en"}, 32'(mac_en), 32'(rd_exp(c - PL, s_lo, s_hi, ns)));
            chk({name, ":mac_last"}, 32'(mac_last), 32'(c == VL + 1 + PL + ns));
            chk({name, ":res_valid"}, 32'(res_valid), 32'((c >= t_rv) && (c <= t_rv + hold)));
            if (mac_en) n_mac++;
            tick();
        end
        chk({name, ":mac_count"}, 32'(n_mac), 32'(VL));
        start_valid = 1'b0;
        stall       = 1'b0;
        res_ready   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_bad;
        rstn        = 1'b0;
        start_valid = 1'b0;
        abort       = 1'b0;
        stall       = 1'b0;
        res_ready   = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:acc_clr", 32'(acc_clr), 32'd0);
        chk("rst:rd_en", 32'(rd_en), 32'd0);
        chk("rst:rd_addr", 32'(rd_addr), 32'd0);
        chk("rst:mac_en", 32'(mac_en), 32'd0);
        chk("rst:mac_last", 32'(mac_last), 32'd0);
        chk("rst:res_valid", 32'(res_valid), 32'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("rel:start_ready", 32'(start_ready), 32'd1);
        chk("rel:busy", 32'(busy), 32'd0);
        tick();

        // Nominal, stalled and back-pressured vectors
        run_vec("nom", 1, 0, 0);
        run_vec("stall", 10, 12, 0);
        run_vec("bp", 1, 0, 5);

        // Abort mid-RUN at rd_addr 30
        start_valid = 1'b1;
        @(negedge clk);
        chk("ab:start_ready", 32'(start_ready), 32'd1);
        tick();
        start_valid = 1'b0;
        repeat (31) tick();
        abort = 1'b1;
        @(negedge clk);
        chk("ab:rd_addr", 32'(rd_addr), 32'd30);
        chk("ab:rd_en", 32'(rd_en), 32'd1);
        chk("ab:start_ready_during", 32'(start_ready), 32'd0);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("ab:busy", 32'(busy), 32'd0);
        chk("ab:mac_en", 32'(mac_en), 32'd0);
        chk("ab:mac_last", 32'(mac_last), 32'd0);
        chk("ab:res_valid", 32'(res_valid), 32'd0);
        chk("ab:start_ready", 32'(start_ready), 32'd1);
        chk("ab:rd_en_after", 32'(rd_en), 32'd0);
        n_bad = 0;
        for (int i = 0; i < 75; i++) begin
            tick();
            @(negedge clk);
            if (mac_en || mac_last || res_valid || busy || acc_clr) n_bad++;
        end
        chk("ab:quiet_cycles", 32'(n_bad), 32'd0);
        tick();
        run_vec("post_abort", 1, 0, 0);

        // Abort and start together in IDLE
        abort       = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        chk("abst:start_ready", 32'(start_ready), 32'd0);
        tick();
        abort       = 1'b0;
        start_valid = 1'b0;
        @(negedge clk);
        chk("abst:busy", 32'(busy), 32'd0);
        chk("abst:acc_clr", 32'(acc_clr), 32'd0);
        chk("abst:start_ready", 32'(start_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("abst:busy2", 32'(busy), 32'd0);
        chk("abst:acc_clr2", 32'(acc_clr), 32'd0);
        tick();

        // Reset during DRAIN (cycle 66)
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (65) tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("rdr:busy_before", 32'(busy), 32'd1);
        chk("rdr:rd_en_before", 32'(rd_en), 32'd0);
        chk("rdr:mac_en_before", 32'(mac_en), 32'd1);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("rdr:busy", 32'(busy), 32'd0);
        chk("rdr:mac_en", 32'(mac_en), 32'd0);
        chk("rdr:mac_last", 32'(mac_last), 32'd0);
        chk("rdr:res_valid", 32'(res_valid), 32'd0);
        chk("rdr:rd_addr", 32'(rd_addr), 32'd0);
        chk("rdr:start_ready", 32'(start_ready), 32'd1);
        n_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (mac_en || mac_last || res_valid || busy) n_bad++;
        end
        chk("rdr:quiet_cycles", 32'(n_bad), 32'd0);
        tick();
        run_vec("post_rst", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
